nonce_result_collector: RTL and testbench
=========================================

NONCE_RESULT_COLLECTOR -- requirements
Module: nonce_result_collector

Interface
REQ-001 The block SHALL have parameter LOG2_NUM_CORES, default 1: log2 of the lattice core count, and the width of partition_i.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: the number of nonce FIFO entries, a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port valid_i, input, 1 bit: the last lattice stage presents a result this cycle.
REQ-006 The block SHALL have port newBlock_i, input, 1 bit: qualified by valid_i; this result is the first round of a new block.
REQ-007 The block SHALL have port success_i, input, 1 bit: qualified by valid_i; some core met the target.
REQ-008 The block SHALL have port partition_i, input, LOG2_NUM_CORES bits: qualified by success_i; index of the winning core.
REQ-009 The block SHALL have port nonce_o, output, 32 bits: the winning nonce at the FIFO head.
REQ-010 The block SHALL have port nonce_valid_o, output, 1 bit: nonce_o holds valid data.
REQ-011 The block SHALL have port nonce_ready_i, input, 1 bit: the consumer accepts nonce_o.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: sticky flag; a nonce was dropped because the FIFO was full.
REQ-013 The block SHALL have port exhausted_o, output, 1 bit: sticky flag; the nonce space of the current block is used up.

Function
REQ-014 The block SHALL implement the states IDLE, SEARCH and EXHAUSTED. Reset enters IDLE.
REQ-015 In IDLE the block SHALL ignore valid_i results that have newBlock_i=0.
REQ-016 In any state, valid_i&&newBlock_i SHALL do all of the following: move to SEARCH, set round = 0 for this result, flush the FIFO, and clear overflow_o and exhausted_o.
REQ-017 The round counter SHALL be RW = 32-LOG2_NUM_CORES bits wide. In SEARCH it SHALL increment by 1 on each valid_i with newBlock_i=0.
REQ-018 The nonce SHALL be {round, partition_i}, 32 bits, where round is the value that applies to the current result.
REQ-019 A result with valid_i&&success_i in SEARCH, or with newBlock_i, SHALL push its nonce into the FIFO at the next clock edge.
REQ-020 A result in the round-all-ones cycle SHALL be processed normally. After it the block SHALL move to EXHAUSTED and set exhausted_o=1 from the next cycle.
REQ-021 In EXHAUSTED the block SHALL ignore valid_i results that have newBlock_i=0. The round counter SHALL not wrap.
REQ-022 nonce_valid_o SHALL equal FIFO non-empty. nonce_o SHALL be the head entry, registered and stable while nonce_valid_o&&!nonce_ready_i.
REQ-023 The FIFO SHALL pop on nonce_valid_o&&nonce_ready_i. A pop SHALL complete in the same cycle, with no combinational path from nonce_ready_i to any internal state other than the pop itself.
REQ-024 A push that arrives when the FIFO is full SHALL be dropped and SHALL set overflow_o, unless a pop happens in the same cycle. In that case the push SHALL be accepted.
REQ-025 A simultaneous push and pop when the FIFO is empty SHALL not occur. A push into an empty FIFO SHALL raise nonce_valid_o on the next cycle.
REQ-026 A flush (REQ-016) SHALL take priority over a pop in the same cycle. After the flush the FIFO SHALL hold only the new block's push, if there is one.
REQ-027 Push-to-nonce_valid_o latency SHALL be 1 cycle. Throughput SHALL be one push and one pop per cycle.
REQ-028 The read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH. The full and empty conditions SHALL be derived from these pointers.

Reset
REQ-029 When rst=1 at a clock edge, the block SHALL enter IDLE, set round=0, empty the FIFO, and drive nonce_valid_o=0, overflow_o=0, exhausted_o=0 and nonce_o=0 from the next cycle.
REQ-030 Reset SHALL override every simultaneous input, including valid_i&&newBlock_i and nonce_ready_i.
REQ-031 Reset mid-block SHALL discard all pending nonces. A following newBlock_i SHALL be required to resume.

Verification
REQ-032 Scenario: LOG2_NUM_CORES=1. Drive newBlock_i plus 4 plain valid_i results, with success_i, partition_i=1 on the third result. The block SHALL output one nonce_o=0x00000005 and hold overflow_o=0.
REQ-033 Scenario: FIFO_DEPTH=4 with nonce_ready_i=0. Drive 5 successive successes in rounds 1..5 with partition 0. The FIFO SHALL hold 0x2,0x4,0x6,0x8, and overflow_o SHALL be 1 from the cycle after the fifth success.
REQ-034 Scenario: full FIFO with nonce_ready_i=1 and a success arriving in the same cycle. The pop and the push SHALL both happen, the occupancy SHALL stay 4, and overflow_o SHALL stay 0.
REQ-035 Scenario: force round to 0x7FFFFFFE, then drive 3 valid_i results. The first two results SHALL be processed and exhausted_o SHALL rise after the second. A success on the third result SHALL not be pushed.
REQ-036 Scenario: 2 pending nonces, then newBlock_i with success_i, partition_i=1, and nonce_ready_i=1 in the same cycle. The old entries SHALL be flushed, and the next cycle SHALL show nonce_o=0x00000001 with nonce_valid_o=1 and flags clear.
REQ-037 Scenario: rst pulse with 3 pending nonces and exhausted_o=1. The next cycle SHALL show all outputs 0, and success results SHALL be ignored until newBlock_i.

Source files
------------

// File: rtl/nonce_result_collector_if.sv
// Result/nonce bus between the last lattice stage, the collector and the
// nonce consumer.
//   valid_i, newBlock_i, success_i, partition_i : result from the lattice
//   nonce_o, nonce_valid_o, nonce_ready_i       : nonce stream to the consumer
//   overflow_o, exhausted_o                     : sticky status flags
// slave  : the collector side
// master : the lattice / consumer side (the testbench)
interface nonce_result_collector_if #(
  parameter int LOG2_NUM_CORES = 1
);
  logic                      valid_i;
  logic                      newBlock_i;
  logic                      success_i;
  logic [LOG2_NUM_CORES-1:0] partition_i;
  logic [31:0]               nonce_o;
  logic                      nonce_valid_o;
  logic                      nonce_ready_i;
  logic                      overflow_o;
  logic                      exhausted_o;

  modport slave (
    input  valid_i, newBlock_i, success_i, partition_i, nonce_ready_i,
    output nonce_o, nonce_valid_o, overflow_o, exhausted_o
  );

  modport master (
    output valid_i, newBlock_i, success_i, partition_i, nonce_ready_i,
    input  nonce_o, nonce_valid_o, overflow_o, exhausted_o
  );
endinterface

// File: rtl/nonce_result_collector.sv
// Collects winning nonces from the lattice search and queues them for the
// consumer. Tracks the search round, builds nonce = {round, partition},
// buffers it in a small FIFO and flags overflow / nonce-space exhaustion.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : nonce_result_collector_if.slave (result in, nonce out, flags)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no block yet; plain results ignored
// SEARCH    | block in progress; rounds count up, successes are queued
// EXHAUSTED | all-ones round done; plain results ignored until new block
module nonce_result_collector #(
  parameter int LOG2_NUM_CORES = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input logic                    clk,
  input logic                    rst,
  nonce_result_collector_if.slave bus
);
  localparam int RW = 32 - LOG2_NUM_CORES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, EXHAUSTED} state_t;

  state_t        state;
  // Round that the next plain result in SEARCH will carry.
  logic [RW-1:0] round;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [31:0]   head;
  logic          overflow;
  logic          exhausted;

  logic          start;
  logic          plain;
  logic [RW-1:0] cur_round;
  logic [31:0]   nonce_in;
  logic          push;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic [PW-1:0] rptr_n;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  always_comb begin
    start     = bus.valid_i & bus.newBlock_i;
    plain     = bus.valid_i & ~bus.newBlock_i & (state == SEARCH);
    cur_round = start ? '0 : round;
    nonce_in  = {cur_round, bus.partition_i};
    push      = bus.valid_i & bus.success_i & (bus.newBlock_i | (state == SEARCH));
    empty     = (wptr == rptr);
    full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop       = ~empty & bus.nonce_ready_i;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok   = push & (~full | pop);
    rptr_n    = rptr + PW'(pop);
    // A new block flushes, so its nonce always lands in slot 0.
    mem_we    = ~rst & (start ? push : push_ok);
    mem_waddr = start ? '0 : wptr[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= nonce_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      round     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      head      <= '0;
      overflow  <= 1'b0;
      exhausted <= 1'b0;
    end else if (start) begin
      // Flush wins over any pop in the same cycle.
      state     <= SEARCH;
      round     <= RW'(1);
      rptr      <= '0;
      overflow  <= 1'b0;
      exhausted <= 1'b0;
      if (push) begin
        wptr <= PW'(1);
        head <= nonce_in;
      end else begin
        wptr <= '0;
      end
    end else begin
      rptr <= rptr_n;
      if (push_ok) wptr <= wptr + PW'(1);
      if (push && !push_ok) overflow <= 1'b1;
      // head register tracks the entry at the read pointer after this edge;
      // when the FIFO would otherwise be empty the incoming nonce is the head.
      if (wptr == rptr_n) begin
        if (push_ok) head <= nonce_in;
      end else begin
        head <= mem[rptr_n[AW-1:0]];
      end
      if (plain) begin
        if (&round) begin
          state     <= EXHAUSTED;
          exhausted <= 1'b1;
        end else begin
          round <= round + RW'(1);
        end
      end
    end
  end

  assign bus.nonce_o       = head;
  assign bus.nonce_valid_o = ~empty;
  assign bus.overflow_o    = overflow;
  assign bus.exhausted_o   = exhausted;
endmodule

// File: tb/tb_nonce_result_collector.sv
module tb_nonce_result_collector;
  logic clk;
  logic rst;

  nonce_result_collector_if #(.LOG2_NUM_CORES(1))  bus1();
  nonce_result_collector_if #(.LOG2_NUM_CORES(27)) bus2();

  nonce_result_collector #(.LOG2_NUM_CORES(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );
  // Wide partition leaves a 5-bit round so exhaustion is reachable.
  nonce_result_collector #(.LOG2_NUM_CORES(27), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // ---------------- behavioural model of dut1 ----------------
  localparam int DEPTH = 4;
  localparam longint unsigned MAX_ROUND = 64'h7FFF_FFFF;
  logic [31:0]     q[$];
  int              mode = 0;      // 0 idle, 1 searching, 2 exhausted
  longint unsigned next_round = 0;
  bit              m_ovf = 0;
  bit              m_exh = 0;
  bit              zero_chk = 0;

  always @(posedge clk) begin
    bit r, v, nb, s, p, rdy, popping;
    r = rst; v = bus1.valid_i; nb = bus1.newBlock_i; s = bus1.success_i;
    p = bus1.partition_i[0]; rdy = bus1.nonce_ready_i;
    popping = (q.size() > 0) && rdy;
    zero_chk = r;
    if (r) begin
      q.delete(); mode = 0; next_round = 0; m_ovf = 0; m_exh = 0;
    end else if (v && nb) begin
      q.delete(); mode = 1; next_round = 1; m_ovf = 0; m_exh = 0;
      if (s) q.push_back({31'd0, p});
    end else begin
      if (popping) void'(q.pop_front());
      if (v && mode == 1) begin
        if (s) begin
          if (q.size() < DEPTH) q.push_back(32'((next_round * 2) + p));
          else m_ovf = 1;
        end
        if (next_round == MAX_ROUND) begin
          mode = 2; m_exh = 1;
        end else begin
          next_round++;
        end
      end
    end
    #1;
    vectors++;
    if (bus1.nonce_valid_o !== (q.size() > 0)) begin
      errs++;
      $display("FAIL model_valid t=%0t: got %b, want %b", $time, bus1.nonce_valid_o, q.size() > 0);
    end
    if (q.size() > 0 && bus1.nonce_o !== q[0]) begin
      errs++;
      $display("FAIL model_nonce t=%0t: got %h, want %h", $time, bus1.nonce_o, q[0]);
    end
    if (zero_chk && bus1.nonce_o !== 32'd0) begin
      errs++;
      $display("FAIL model_nonce_rst t=%0t: got %h, want 0", $time, bus1.nonce_o);
    end
    if (bus1.overflow_o !== m_ovf) begin
      errs++;
      $display("FAIL model_overflow t=%0t: got %b, want %b", $time, bus1.overflow_o, m_ovf);
    end
    if (bus1.exhausted_o !== m_exh) begin
      errs++;
      $display("FAIL model_exhausted t=%0t: got %b, want %b", $time, bus1.exhausted_o, m_exh);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit r, input bit v, input bit nb, input bit s,
                      input bit p, input bit rdy);
    rst = r;
    bus1.valid_i = v; bus1.newBlock_i = nb; bus1.success_i = s;
    bus1.partition_i = p; bus1.nonce_ready_i = rdy;
    @(posedge clk); #2;
  endtask

  task automatic step2(input bit r, input bit v, input bit nb, input bit s,
                       input logic [26:0] p, input bit rdy);
    rst = r;
    bus1.valid_i = 0; bus1.newBlock_i = 0; bus1.success_i = 0;
    bus1.partition_i = 0; bus1.nonce_ready_i = 0;
    bus2.valid_i = v; bus2.newBlock_i = nb; bus2.success_i = s;
    bus2.partition_i = p; bus2.nonce_ready_i = rdy;
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // newBlock, 28 empty rounds, then successes in rounds 29, 30, 31 (last).
  task automatic exhaust2();
    step2(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 28; i++) step2(0, 1, 0, 0, 0, 0);
    step2(0, 1, 0, 1, 27'd1, 0);
    chk("exh_r29_flag", 32'(bus2.exhausted_o), 0);
    step2(0, 1, 0, 1, 27'd5, 0);
    chk("exh_r30_flag", 32'(bus2.exhausted_o), 0);
    step2(0, 1, 0, 1, 27'd3, 0);
    chk("exh_r31_flag", 32'(bus2.exhausted_o), 1);
    chk("exh_head", bus2.nonce_o, 32'hE800_0001);
  endtask

  initial begin
    bus2.valid_i = 0; bus2.newBlock_i = 0; bus2.success_i = 0;
    bus2.partition_i = 0; bus2.nonce_ready_i = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(bus1.nonce_valid_o), 0);
    chk("rst_nonce", bus1.nonce_o, 0);
    chk("rst_flags", {30'd0, bus1.overflow_o, bus1.exhausted_o}, 0);
    step(0, 1, 0, 1, 1, 0);
    chk("idle_ignore", 32'(bus1.nonce_valid_o), 0);

    // overflow: rounds 1..5, partition 0, consumer stalled
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 0);
    chk("ovf_before", 32'(bus1.overflow_o), 0);
    step(0, 1, 0, 1, 0, 0);
    chk("ovf_after", 32'(bus1.overflow_o), 1);
    chk("ovf_head", bus1.nonce_o, 32'h2);
    step(0, 0, 0, 0, 0, 1); chk("ovf_q1", bus1.nonce_o, 32'h4);
    step(0, 0, 0, 0, 0, 1); chk("ovf_q2", bus1.nonce_o, 32'h6);
    step(0, 0, 0, 0, 0, 1); chk("ovf_q3", bus1.nonce_o, 32'h8);
    step(0, 0, 0, 0, 0, 1); chk("ovf_drained", 32'(bus1.nonce_valid_o), 0);

    // flush with a pending pop and a new-block success
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("flush_nonce", bus1.nonce_o, 32'h1);
    chk("flush_valid", 32'(bus1.nonce_valid_o), 1);
    chk("flush_flags", {30'd0, bus1.overflow_o, bus1.exhausted_o}, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("flush_only_one", 32'(bus1.nonce_valid_o), 0);

    // full FIFO with simultaneous pop and push
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 1, 1);
    chk("fullpp_ovf", 32'(bus1.overflow_o), 0);
    chk("fullpp_head", bus1.nonce_o, 32'h4);
    step(0, 0, 0, 0, 0, 1); chk("fullpp_q1", bus1.nonce_o, 32'h6);
    step(0, 0, 0, 0, 0, 1); chk("fullpp_q2", bus1.nonce_o, 32'h8);
    step(0, 0, 0, 0, 0, 1); chk("fullpp_q3", bus1.nonce_o, 32'hB);
    step(0, 0, 0, 0, 0, 1); chk("fullpp_drained", 32'(bus1.nonce_valid_o), 0);

    // single success on the third result of a block
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("basic_nonce", bus1.nonce_o, 32'h5);
    chk("basic_valid", 32'(bus1.nonce_valid_o), 1);
    chk("basic_ovf", 32'(bus1.overflow_o), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("basic_drained", 32'(bus1.nonce_valid_o), 0);

    // reset overrides new block and pop, pending nonces lost
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 1, 0);
    step(1, 1, 1, 1, 1, 1);
    chk("rst1_valid", 32'(bus1.nonce_valid_o), 0);
    chk("rst1_nonce", bus1.nonce_o, 0);
    step(0, 1, 0, 1, 1, 0);
    chk("rst1_ignore", 32'(bus1.nonce_valid_o), 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      bit v, nb, rdy;
      v   = ($urandom_range(0, 3) != 0);
      nb  = v && ($urandom_range(0, 19) == 0);
      rdy = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 399) == 0, v, nb, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), rdy);
    end

    // exhaustion on the narrow-round instance
    step2(1, 0, 0, 0, 0, 0);
    exhaust2();
    step2(0, 1, 0, 1, 27'd7, 0);
    chk("exh_hold", 32'(bus2.exhausted_o), 1);
    step2(0, 0, 0, 0, 0, 1); chk("exh_q1", bus2.nonce_o, 32'hF000_0005);
    step2(0, 0, 0, 0, 0, 1); chk("exh_q2", bus2.nonce_o, 32'hF800_0003);
    step2(0, 0, 0, 0, 0, 1); chk("exh_no_push", 32'(bus2.nonce_valid_o), 0);

    // reset with pending nonces and exhausted set
    exhaust2();
    step2(1, 1, 1, 1, 27'd9, 1);
    chk("rst2_nonce", bus2.nonce_o, 0);
    chk("rst2_outs", {29'd0, bus2.nonce_valid_o, bus2.overflow_o, bus2.exhausted_o}, 0);
    step2(0, 1, 0, 1, 27'd4, 0);
    chk("rst2_ignore", 32'(bus2.nonce_valid_o), 0);
    step2(0, 1, 1, 1, 27'd2, 0);
    chk("rst2_resume", bus2.nonce_o, 32'h2);
    chk("rst2_resume_v", 32'(bus2.nonce_valid_o), 1);

    step2(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
